// File: rtl/ros2_app_data_ctrl_pkg.sv
// Shared definitions for the ROS2 app-data controller: capacity default,
// publish/subscribe state encodings and a length clamp helper.
package ros2_app_data_ctrl_pkg;

  localparam int ROS2_MAX_APP_DATA_LEN = 32;

  typedef enum logic [1:0] {
    P_IDLE = 2'd0,
    P_REQ  = 2'd1,
    P_LOAD = 2'd2,
    P_REL  = 2'd3
  } pub_state_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RD   = 2'd2,
    S_REL  = 2'd3
  } sub_state_t;

  // Limit a length reported by the core to the buffer capacity.
  function automatic logic [7:0] clamp_len(input logic [7:0] len, input logic [7:0] max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/ros2_app_sub_mem.sv
// Received-message memory: MAX_LEN x 8, synchronous write, asynchronous read.
// Contents are deliberately not reset.
module ros2_app_sub_mem #(
  parameter int MAX_LEN = 32,
  parameter int AW      = $clog2(MAX_LEN)
) (
  input  logic          clk_int,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [7:0]    i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [7:0]    o_rd_data
);

  logic [7:0] r_mem [MAX_LEN];

  // Core write port.
  always_ff @(posedge clk_int) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/ros2_app_data_ctrl.sv
// Application-side controller for the ROS2 app-data buffers. The publish path
// stages a user byte stream and loads it atomically into the published
// register under req/grant/rel; the subscribe path owns the received-message
// memory and streams each message out under its own req/grant/rel.
module ros2_app_data_ctrl
  import ros2_app_data_ctrl_pkg::*;
#(
  parameter int MAX_LEN       = ROS2_MAX_APP_DATA_LEN,
  parameter int GRANT_TIMEOUT = 250000000
) (
  input  logic                       clk_int,
  input  logic                       rst_n,
  input  logic                       pub_wr_valid,
  output logic                       pub_wr_ready,
  input  logic [7:0]                 pub_wr_data,
  input  logic                       pub_wr_last,
  output logic                       pub_err,
  output logic                       pub_ovf,
  output logic [MAX_LEN*8-1:0]       ros2_pub_app_data,
  output logic [7:0]                 ros2_pub_app_data_len,
  output logic                       ros2_pub_app_data_req,
  output logic                       ros2_pub_app_data_rel,
  input  logic                       ros2_pub_app_data_grant,
  input  logic [$clog2(MAX_LEN)-1:0] ros2_sub_app_data_addr,
  input  logic                       ros2_sub_app_data_ce,
  input  logic                       ros2_sub_app_data_we,
  input  logic [7:0]                 ros2_sub_app_data_wdata,
  input  logic [7:0]                 ros2_sub_app_data_len,
  input  logic                       ros2_sub_app_data_recv,
  output logic                       ros2_sub_app_data_req,
  output logic                       ros2_sub_app_data_rel,
  input  logic                       ros2_sub_app_data_grant,
  output logic                       sub_rd_valid,
  input  logic                       sub_rd_ready,
  output logic [7:0]                 sub_rd_data,
  output logic                       sub_rd_last
);

  localparam int          AW     = $clog2(MAX_LEN);
  localparam logic [7:0]  LEN8   = 8'(MAX_LEN);
  localparam logic [31:0] TO_LIM = 32'(GRANT_TIMEOUT - 1);

  // ---------------- publish side ----------------
  pub_state_t                r_pub_state, w_pub_nxt;
  logic [7:0]                r_cnt;
  logic [7:0]                r_len;
  logic [31:0]               r_timer;
  logic [MAX_LEN-1:0][7:0]   r_staging;
  logic [MAX_LEN-1:0][7:0]   r_pub_data;
  logic [7:0]                r_pub_len;
  logic [7:0]                w_len_next;
  logic                      w_pub_wr_ready, w_pub_req, w_pub_rel, w_pub_err, w_pub_ovf;
  logic                      w_stage_we, w_cnt_inc, w_cnt_clr, w_len_latch, w_timer_clr, w_load;

  assign w_len_next = (r_cnt >= LEN8) ? LEN8 : r_cnt + 8'd1;

  // Publish state register.
  always_ff @(posedge clk_int or negedge rst_n) begin
    if (!rst_n) r_pub_state <= P_IDLE;
    else        r_pub_state <= w_pub_nxt;
  end

  // Publish next-state and strobes; the load happens on the grant edge so the
  // new message is visible in the cycle after grant.
  always_comb begin
    w_pub_nxt      = r_pub_state;
    w_pub_wr_ready = 1'b0;
    w_pub_req      = 1'b0;
    w_pub_rel      = 1'b0;
    w_pub_err      = 1'b0;
    w_pub_ovf      = 1'b0;
    w_stage_we     = 1'b0;
    w_cnt_inc      = 1'b0;
    w_cnt_clr      = 1'b0;
    w_len_latch    = 1'b0;
    w_timer_clr    = 1'b0;
    w_load         = 1'b0;
    case (r_pub_state)
      P_IDLE: begin
        w_pub_wr_ready = 1'b1;
        if (pub_wr_valid) begin
          if (r_cnt < LEN8) begin
            w_stage_we = 1'b1;
            w_cnt_inc  = 1'b1;
          end else begin
            w_pub_ovf  = 1'b1;
          end
          if (pub_wr_last) begin
            w_len_latch = 1'b1;
            w_timer_clr = 1'b1;
            w_pub_nxt   = P_REQ;
          end
        end
      end
      P_REQ: begin
        w_pub_req = 1'b1;
        if (ros2_pub_app_data_grant) begin
          w_load    = 1'b1;
          w_pub_nxt = P_LOAD;
        end else if (r_timer >= TO_LIM) begin
          w_pub_err = 1'b1;
          w_cnt_clr = 1'b1;
          w_pub_nxt = P_IDLE;
        end
      end
      P_LOAD: w_pub_nxt = P_REL;
      P_REL: begin
        w_pub_rel = 1'b1;
        w_cnt_clr = 1'b1;
        w_pub_nxt = P_IDLE;
      end
      default: w_pub_nxt = P_IDLE;
    endcase
  end

  // Byte counter, latched length and grant-wait timer.
  always_ff @(posedge clk_int or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= 8'd0;
      r_len   <= 8'd0;
      r_timer <= 32'd0;
    end else begin
      if (w_cnt_clr)      r_cnt <= 8'd0;
      else if (w_cnt_inc) r_cnt <= r_cnt + 8'd1;
      if (w_len_latch)    r_len <= w_len_next;
      if (w_timer_clr)                r_timer <= 32'd0;
      else if (r_pub_state == P_REQ)  r_timer <= r_timer + 32'd1;
    end
  end

  // Staging buffer; stale bytes beyond the length are masked at load time.
  always_ff @(posedge clk_int) begin
    if (w_stage_we) r_staging[r_cnt[AW-1:0]] <= pub_wr_data;
  end

  // Published message register, loaded in parallel with tail bytes zeroed.
  always_ff @(posedge clk_int or negedge rst_n) begin
    if (!rst_n) begin
      r_pub_data <= '0;
      r_pub_len  <= 8'd0;
    end else if (w_load) begin
      for (int i = 0; i < MAX_LEN; i++)
        r_pub_data[i] <= (i < int'(r_len)) ? r_staging[i] : 8'h00;
      r_pub_len <= r_len;
    end
  end

  assign pub_wr_ready          = w_pub_wr_ready;
  assign pub_err               = w_pub_err;
  assign pub_ovf               = w_pub_ovf;
  assign ros2_pub_app_data     = r_pub_data;
  assign ros2_pub_app_data_len = r_pub_len;
  assign ros2_pub_app_data_req = w_pub_req;
  assign ros2_pub_app_data_rel = w_pub_rel;

  // ---------------- subscribe side ----------------
  sub_state_t  r_sub_state, w_sub_nxt;
  logic [7:0]  r_rd_ptr;
  logic [7:0]  r_sub_len;
  logic        r_pend;
  logic        w_sub_req, w_sub_rel, w_sub_valid, w_sub_take, w_sub_adv;
  logic        w_sub_last, w_sub_enter_req;
  logic [7:0]  w_mem_rd;
  logic [7:0]  w_sub_len_in;

  assign w_sub_len_in    = clamp_len(ros2_sub_app_data_len, LEN8);
  assign w_sub_last      = (r_rd_ptr == r_sub_len - 8'd1);
  assign w_sub_enter_req = (w_sub_nxt == S_REQ) && (r_sub_state != S_REQ);

  ros2_app_sub_mem #(
    .MAX_LEN (MAX_LEN),
    .AW      (AW)
  ) u_sub_mem (
    .clk_int   (clk_int),
    .i_wr_en   (ros2_sub_app_data_ce & ros2_sub_app_data_we),
    .i_wr_addr (ros2_sub_app_data_addr),
    .i_wr_data (ros2_sub_app_data_wdata),
    .i_rd_addr (r_rd_ptr[AW-1:0]),
    .o_rd_data (w_mem_rd)
  );

  // Subscribe state register.
  always_ff @(posedge clk_int or negedge rst_n) begin
    if (!rst_n) r_sub_state <= S_IDLE;
    else        r_sub_state <= w_sub_nxt;
  end

  // Subscribe next-state and handshake outputs.
  always_comb begin
    w_sub_nxt   = r_sub_state;
    w_sub_req   = 1'b0;
    w_sub_rel   = 1'b0;
    w_sub_valid = 1'b0;
    w_sub_take  = 1'b0;
    w_sub_adv   = 1'b0;
    case (r_sub_state)
      S_IDLE: if (ros2_sub_app_data_recv) w_sub_nxt = S_REQ;
      S_REQ: begin
        w_sub_req = 1'b1;
        if (ros2_sub_app_data_grant) begin
          w_sub_take = 1'b1;
          w_sub_nxt  = (w_sub_len_in == 8'd0) ? S_REL : S_RD;
        end
      end
      S_RD: begin
        w_sub_req   = 1'b1;
        w_sub_valid = 1'b1;
        if (sub_rd_ready) begin
          w_sub_adv = 1'b1;
          if (w_sub_last) w_sub_nxt = S_REL;
        end
      end
      S_REL: begin
        w_sub_rel = 1'b1;
        w_sub_nxt = (r_pend || ros2_sub_app_data_recv) ? S_REQ : S_IDLE;
      end
      default: w_sub_nxt = S_IDLE;
    endcase
  end

  // Read pointer and sampled length.
  always_ff @(posedge clk_int or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr  <= 8'd0;
      r_sub_len <= 8'd0;
    end else if (w_sub_take) begin
      r_rd_ptr  <= 8'd0;
      r_sub_len <= w_sub_len_in;
    end else if (w_sub_adv) begin
      r_rd_ptr  <= r_rd_ptr + 8'd1;
    end
  end

  // One-deep pending flag: recvs seen while busy coalesce into one re-request.
  always_ff @(posedge clk_int or negedge rst_n) begin
    if (!rst_n)                                                        r_pend <= 1'b0;
    else if (w_sub_enter_req)                                          r_pend <= 1'b0;
    else if (ros2_sub_app_data_recv && (r_sub_state != S_IDLE))        r_pend <= 1'b1;
  end

  assign ros2_sub_app_data_req = w_sub_req;
  assign ros2_sub_app_data_rel = w_sub_rel;
  assign sub_rd_valid          = w_sub_valid;
  assign sub_rd_data           = w_sub_valid ? w_mem_rd : 8'h00;
  assign sub_rd_last           = w_sub_valid & w_sub_last;

endmodule

// File: tb/tb_ros2_app_data_ctrl.sv
// Scoreboard bench for ros2_app_data_ctrl: stimulus pushes expected messages
// and bytes into queues, a negedge monitor pops and compares.
module tb_ros2_app_data_ctrl;

  localparam int MAX_LEN       = 32;
  localparam int GRANT_TIMEOUT = 100;
  localparam int AW            = $clog2(MAX_LEN);

  logic                 clk_int = 1'b0;
  logic                 rst_n   = 1'b0;
  logic                 pub_wr_valid = 1'b0;
  logic                 pub_wr_ready;
  logic [7:0]           pub_wr_data = 8'h00;
  logic                 pub_wr_last = 1'b0;
  logic                 pub_err, pub_ovf;
  logic [MAX_LEN*8-1:0] ros2_pub_app_data;
  logic [7:0]           ros2_pub_app_data_len;
  logic                 ros2_pub_app_data_req, ros2_pub_app_data_rel;
  logic                 ros2_pub_app_data_grant = 1'b0;
  logic [AW-1:0]        ros2_sub_app_data_addr = '0;
  logic                 ros2_sub_app_data_ce = 1'b0;
  logic                 ros2_sub_app_data_we = 1'b0;
  logic [7:0]           ros2_sub_app_data_wdata = 8'h00;
  logic [7:0]           ros2_sub_app_data_len = 8'h00;
  logic                 ros2_sub_app_data_recv = 1'b0;
  logic                 ros2_sub_app_data_req, ros2_sub_app_data_rel;
  logic                 ros2_sub_app_data_grant = 1'b0;
  logic                 sub_rd_valid;
  logic                 sub_rd_ready = 1'b0;
  logic [7:0]           sub_rd_data;
  logic                 sub_rd_last;

  always #5 clk_int = ~clk_int;

  ros2_app_data_ctrl #(
    .MAX_LEN       (MAX_LEN),
    .GRANT_TIMEOUT (GRANT_TIMEOUT)
  ) dut (
    .clk_int                 (clk_int),
    .rst_n                   (rst_n),
    .pub_wr_valid            (pub_wr_valid),
    .pub_wr_ready            (pub_wr_ready),
    .pub_wr_data             (pub_wr_data),
    .pub_wr_last             (pub_wr_last),
    .pub_err                 (pub_err),
    .pub_ovf                 (pub_ovf),
    .ros2_pub_app_data       (ros2_pub_app_data),
    .ros2_pub_app_data_len   (ros2_pub_app_data_len),
    .ros2_pub_app_data_req   (ros2_pub_app_data_req),
    .ros2_pub_app_data_rel   (ros2_pub_app_data_rel),
    .ros2_pub_app_data_grant (ros2_pub_app_data_grant),
    .ros2_sub_app_data_addr  (ros2_sub_app_data_addr),
    .ros2_sub_app_data_ce    (ros2_sub_app_data_ce),
    .ros2_sub_app_data_we    (ros2_sub_app_data_we),
    .ros2_sub_app_data_wdata (ros2_sub_app_data_wdata),
    .ros2_sub_app_data_len   (ros2_sub_app_data_len),
    .ros2_sub_app_data_recv  (ros2_sub_app_data_recv),
    .ros2_sub_app_data_req   (ros2_sub_app_data_req),
    .ros2_sub_app_data_rel   (ros2_sub_app_data_rel),
    .ros2_sub_app_data_grant (ros2_sub_app_data_grant),
    .sub_rd_valid            (sub_rd_valid),
    .sub_rd_ready            (sub_rd_ready),
    .sub_rd_data             (sub_rd_data),
    .sub_rd_last             (sub_rd_last)
  );

  typedef struct packed {
    logic [255:0] data;
    logic [7:0]   len;
  } pub_exp_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } sub_exp_t;

  pub_exp_t pub_q[$];
  sub_exp_t sub_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // monitor-side counters
  int pub_rel_cnt = 0, err_cnt = 0, ovf_cnt = 0, pub_req_cycles = 0;
  int sub_rel_cnt = 0, sub_hs_cnt = 0, sub_req_rise = 0;
  int pub_g_cyc = -100, sub_g_cyc = -100, sub_last_cyc = -100;
  logic sub_prev_valid = 1'b0, sub_prev_req = 1'b0, sub_prev_stall = 1'b0;
  logic sub_had_data = 1'b0;
  logic [7:0] sub_prev_data = 8'h00;
  logic sub_prev_last = 1'b0;

  // responder / driver controls
  logic pub_gnt_en = 1'b0, sub_gnt_en = 1'b0;
  int   pub_gnt_dly = 5, sub_gnt_dly = 2;
  int   ready_mode = 1;  // 0 low, 1 high, 2 toggle

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
  endtask

  always @(posedge clk_int) cyc <= cyc + 1;

  // Scoreboard monitor, sampled on the inactive edge.
  always @(negedge clk_int) begin
    if (!rst_n) begin
      sub_prev_valid = 1'b0;
      sub_prev_req   = 1'b0;
      sub_prev_stall = 1'b0;
      sub_had_data   = 1'b0;
    end else begin
      if (ros2_pub_app_data_req) pub_req_cycles++;
      if (pub_err) err_cnt++;
      if (pub_ovf) ovf_cnt++;
      if (ros2_pub_app_data_req && ros2_pub_app_data_grant) pub_g_cyc = cyc;
      if (cyc == pub_g_cyc + 1 && pub_q.size() > 0)
        check("pub_data_at_grant_plus1", ros2_pub_app_data, pub_q[0].data);
      if (ros2_pub_app_data_rel) begin
        pub_rel_cnt++;
        check("pub_rel_latency", 256'(cyc - pub_g_cyc), 256'(2));
        if (pub_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL pub_unexpected_rel: got rel at cycle %0d required none", cyc);
        end else begin
          pub_exp_t e;
          e = pub_q.pop_front();
          check("pub_data", ros2_pub_app_data, e.data);
          check("pub_len", 256'(ros2_pub_app_data_len), 256'(e.len));
        end
      end

      if (ros2_sub_app_data_req && !sub_prev_req) sub_req_rise++;
      if (ros2_sub_app_data_req && ros2_sub_app_data_grant) sub_g_cyc = cyc;
      if (sub_rd_valid && !sub_prev_valid) begin
        check("sub_first_valid_latency", 256'(cyc - sub_g_cyc), 256'(1));
        sub_had_data = 1'b1;
      end
      if (sub_rd_valid && sub_prev_stall) begin
        check("sub_stall_data_stable", 256'(sub_rd_data), 256'(sub_prev_data));
        check("sub_stall_last_stable", 256'(sub_rd_last), 256'(sub_prev_last));
      end
      if (sub_rd_valid && sub_rd_ready) begin
        sub_hs_cnt++;
        if (sub_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL sub_unexpected_byte: got %0h required none", sub_rd_data);
        end else begin
          sub_exp_t s;
          s = sub_q.pop_front();
          check("sub_data", 256'(sub_rd_data), 256'(s.data));
          check("sub_last", 256'(sub_rd_last), 256'(s.last));
        end
        if (sub_rd_last) sub_last_cyc = cyc;
      end
      if (ros2_sub_app_data_rel) begin
        sub_rel_cnt++;
        if (sub_had_data)
          check("sub_rel_after_last", 256'(cyc - sub_last_cyc), 256'(1));
        sub_had_data = 1'b0;
      end
      sub_prev_stall = sub_rd_valid && !sub_rd_ready;
      sub_prev_data  = sub_rd_data;
      sub_prev_last  = sub_rd_last;
      sub_prev_valid = sub_rd_valid;
      sub_prev_req   = ros2_sub_app_data_req;
    end
  end

  // Pub grant responder: one grant per request episode after pub_gnt_dly cycles.
  initial begin : pub_granter
    int w;
    logic done;
    w = 0; done = 1'b0;
    forever begin
      @(posedge clk_int); #1;
      if (!ros2_pub_app_data_req) begin
        ros2_pub_app_data_grant = 1'b0; w = 0; done = 1'b0;
      end else if (ros2_pub_app_data_grant) begin
        ros2_pub_app_data_grant = 1'b0; done = 1'b1;
      end else if (pub_gnt_en && !done) begin
        if (w >= pub_gnt_dly) ros2_pub_app_data_grant = 1'b1;
        else w++;
      end
    end
  end

  // Sub grant responder.
  initial begin : sub_granter
    int w;
    logic done;
    w = 0; done = 1'b0;
    forever begin
      @(posedge clk_int); #1;
      if (!ros2_sub_app_data_req) begin
        ros2_sub_app_data_grant = 1'b0; w = 0; done = 1'b0;
      end else if (ros2_sub_app_data_grant) begin
        ros2_sub_app_data_grant = 1'b0; done = 1'b1;
      end else if (sub_gnt_en && !done) begin
        if (w >= sub_gnt_dly) ros2_sub_app_data_grant = 1'b1;
        else w++;
      end
    end
  end

  // Sub ready driver.
  initial begin : ready_drv
    forever begin
      @(posedge clk_int); #1;
      case (ready_mode)
        0:       sub_rd_ready = 1'b0;
        1:       sub_rd_ready = 1'b1;
        default: sub_rd_ready = ~sub_rd_ready;
      endcase
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1, "watchdog");
  end

  task automatic pub_byte(input logic [7:0] d, input logic l);
    int g;
    g = 0;
    pub_wr_valid = 1'b1; pub_wr_data = d; pub_wr_last = l;
    while (!pub_wr_ready && g < 500) begin @(posedge clk_int); #1; g++; end
    if (!pub_wr_ready) fail_timeout("pub_byte_ready");
    @(posedge clk_int); #1;
    pub_wr_valid = 1'b0; pub_wr_last = 1'b0;
  endtask

  task automatic wait_pub_rel(input int base);
    int g;
    g = 0;
    while (pub_rel_cnt == base && g < 1000) begin @(posedge clk_int); #1; g++; end
    if (pub_rel_cnt == base) fail_timeout("wait_pub_rel");
  endtask

  task automatic wait_sub_rel(input int target);
    int g;
    g = 0;
    while (sub_rel_cnt < target && g < 1000) begin @(posedge clk_int); #1; g++; end
    if (sub_rel_cnt < target) fail_timeout("wait_sub_rel");
  endtask

  task automatic wait_sub_valid();
    int g;
    g = 0;
    while (!sub_rd_valid && g < 200) begin @(posedge clk_int); #1; g++; end
    if (!sub_rd_valid) fail_timeout("wait_sub_valid");
  endtask

  task automatic core_write(input logic [AW-1:0] a, input logic [7:0] d);
    ros2_sub_app_data_ce = 1'b1; ros2_sub_app_data_we = 1'b1;
    ros2_sub_app_data_addr = a; ros2_sub_app_data_wdata = d;
    @(posedge clk_int); #1;
    ros2_sub_app_data_ce = 1'b0; ros2_sub_app_data_we = 1'b0;
  endtask

  task automatic sub_recv();
    ros2_sub_app_data_recv = 1'b1;
    @(posedge clk_int); #1;
    ros2_sub_app_data_recv = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_ready"}, 256'(pub_wr_ready), 256'(1));
    check({tag, "_pub_req"}, 256'(ros2_pub_app_data_req), 256'(0));
    check({tag, "_pub_rel"}, 256'(ros2_pub_app_data_rel), 256'(0));
    check({tag, "_pub_data"}, ros2_pub_app_data, 256'(0));
    check({tag, "_pub_len"}, 256'(ros2_pub_app_data_len), 256'(0));
    check({tag, "_pub_pulses"}, 256'({pub_err, pub_ovf}), 256'(0));
    check({tag, "_sub_req_rel"}, 256'({ros2_sub_app_data_req, ros2_sub_app_data_rel}), 256'(0));
    check({tag, "_sub_rd"}, 256'({sub_rd_valid, sub_rd_last, sub_rd_data}), 256'(0));
  endtask

  initial begin : main
    logic [255:0] exp_d, snap_d;
    logic [7:0]   snap_len;
    int b_rel, b_ovf, b_err, b_srel, b_hs, b_rise;

    rst_n = 1'b0;
    repeat (3) @(posedge clk_int);
    @(negedge clk_int);
    check_reset_outputs("reset");
    @(posedge clk_int); #1;
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk_int); #1; end

    // basic publish "hi!"
    pub_gnt_en = 1'b1; pub_gnt_dly = 5;
    b_rel = pub_rel_cnt; b_ovf = ovf_cnt;
    pub_q.push_back('{data: 256'h216968, len: 8'd3});
    pub_byte(8'h68, 1'b0);
    pub_byte(8'h69, 1'b0);
    pub_byte(8'h21, 1'b1);
    check("pub_req_after_last", 256'(ros2_pub_app_data_req), 256'(1));
    check("pub_ready_low_in_req", 256'(pub_wr_ready), 256'(0));
    wait_pub_rel(b_rel);
    check("pub_wr_ready_after_rel", 256'(pub_wr_ready), 256'(1));
    repeat (3) begin @(posedge clk_int); #1; end
    check("pub_rel_pulses", 256'(pub_rel_cnt - b_rel), 256'(1));
    check("pub_upper_zero", 256'(ros2_pub_app_data[255:24]), 256'(0));
    check("pub_no_ovf", 256'(ovf_cnt - b_ovf), 256'(0));

    // overflow: 35 bytes 0x01..0x23
    b_rel = pub_rel_cnt; b_ovf = ovf_cnt;
    exp_d = '0;
    for (int i = 0; i < 32; i++) exp_d[8*i +: 8] = 8'(i + 1);
    pub_q.push_back('{data: exp_d, len: 8'd32});
    for (int i = 0; i < 35; i++) pub_byte(8'(i + 1), (i == 34));
    wait_pub_rel(b_rel);
    repeat (2) begin @(posedge clk_int); #1; end
    check("ovf_pulses", 256'(ovf_cnt - b_ovf), 256'(3));
    check("ovf_len", 256'(ros2_pub_app_data_len), 256'(32));
    check("ovf_byte31", 256'(ros2_pub_app_data[255:248]), 256'(8'h20));

    // grant timeout
    pub_gnt_en = 1'b0;
    snap_d = ros2_pub_app_data; snap_len = ros2_pub_app_data_len;
    b_err = err_cnt; b_rel = pub_rel_cnt; pub_req_cycles = 0;
    pub_byte(8'h55, 1'b1);
    begin
      int g;
      g = 0;
      while (err_cnt == b_err && g < 500) begin @(posedge clk_int); #1; g++; end
      if (err_cnt == b_err) fail_timeout("wait_pub_err");
    end
    repeat (2) begin @(posedge clk_int); #1; end
    check("to_req_cycles", 256'(pub_req_cycles), 256'(GRANT_TIMEOUT));
    check("to_err_pulses", 256'(err_cnt - b_err), 256'(1));
    check("to_req_dropped", 256'(ros2_pub_app_data_req), 256'(0));
    check("to_data_unchanged", ros2_pub_app_data, snap_d);
    check("to_len_unchanged", 256'(ros2_pub_app_data_len), 256'(snap_len));
    check("to_no_rel", 256'(pub_rel_cnt - b_rel), 256'(0));
    pub_gnt_en = 1'b1;
    pub_q.push_back('{data: 256'hB2A1, len: 8'd2});
    pub_byte(8'hA1, 1'b0);
    pub_byte(8'hB2, 1'b1);
    wait_pub_rel(b_rel);
    check("pub_q_drained", 256'(pub_q.size()), 256'(0));

    // basic subscribe "abcd", ready toggling
    core_write(0, 8'h61); core_write(1, 8'h62);
    core_write(2, 8'h63); core_write(3, 8'h64);
    ros2_sub_app_data_len = 8'd4;
    sub_gnt_en = 1'b1; sub_gnt_dly = 2; ready_mode = 2;
    sub_q.push_back('{data: 8'h61, last: 1'b0});
    sub_q.push_back('{data: 8'h62, last: 1'b0});
    sub_q.push_back('{data: 8'h63, last: 1'b0});
    sub_q.push_back('{data: 8'h64, last: 1'b1});
    b_srel = sub_rel_cnt; b_hs = sub_hs_cnt;
    sub_recv();
    check("sub_req_after_recv", 256'(ros2_sub_app_data_req), 256'(1));
    wait_sub_rel(b_srel + 1);
    repeat (3) begin @(posedge clk_int); #1; end
    check("sub_rel_pulses", 256'(sub_rel_cnt - b_srel), 256'(1));
    check("sub_hs_count", 256'(sub_hs_cnt - b_hs), 256'(4));
    check("sub_q_drained", 256'(sub_q.size()), 256'(0));

    // coalesced recv during S_RD, followed by an empty message
    core_write(0, 8'h78); core_write(1, 8'h79); core_write(2, 8'h7A);
    ros2_sub_app_data_len = 8'd3;
    ready_mode = 0;
    sub_q.push_back('{data: 8'h78, last: 1'b0});
    sub_q.push_back('{data: 8'h79, last: 1'b0});
    sub_q.push_back('{data: 8'h7A, last: 1'b1});
    b_srel = sub_rel_cnt; b_hs = sub_hs_cnt; b_rise = sub_req_rise;
    sub_recv();
    wait_sub_valid();
    ros2_sub_app_data_len = 8'd0;
    sub_recv();
    @(posedge clk_int); #1;
    sub_recv();
    ready_mode = 1;
    wait_sub_rel(b_srel + 2);
    repeat (20) begin @(posedge clk_int); #1; end
    check("coal_rel_pulses", 256'(sub_rel_cnt - b_srel), 256'(2));
    check("coal_req_rises", 256'(sub_req_rise - b_rise), 256'(2));
    check("coal_hs_count", 256'(sub_hs_cnt - b_hs), 256'(3));
    check("coal_q_drained", 256'(sub_q.size()), 256'(0));

    // reset while publish waits in P_REQ
    pub_gnt_en = 1'b0;
    pub_byte(8'h11, 1'b1);
    repeat (5) begin @(posedge clk_int); #1; end
    check("rstp_in_req", 256'(ros2_pub_app_data_req), 256'(1));
    rst_n = 1'b0;
    @(negedge clk_int);
    check_reset_outputs("rst_pub");
    @(posedge clk_int); #1;
    rst_n = 1'b1;
    pub_gnt_en = 1'b1;
    b_rel = pub_rel_cnt;
    pub_q.push_back('{data: 256'h42, len: 8'd1});
    pub_byte(8'h42, 1'b1);
    wait_pub_rel(b_rel);

    // reset while subscribe streams in S_RD, with a recv pending
    ros2_sub_app_data_len = 8'd3;
    ready_mode = 0;
    sub_recv();
    wait_sub_valid();
    sub_recv();
    b_rise = sub_req_rise;
    rst_n = 1'b0;
    @(negedge clk_int);
    check_reset_outputs("rst_sub");
    @(posedge clk_int); #1;
    rst_n = 1'b1;
    repeat (10) begin @(posedge clk_int); #1; end
    check("rsts_pending_cleared", 256'(sub_req_rise - b_rise), 256'(0));
    ros2_sub_app_data_len = 8'd4;
    ready_mode = 1;
    sub_q.push_back('{data: 8'h78, last: 1'b0});
    sub_q.push_back('{data: 8'h79, last: 1'b0});
    sub_q.push_back('{data: 8'h7A, last: 1'b0});
    sub_q.push_back('{data: 8'h64, last: 1'b1});
    b_srel = sub_rel_cnt;
    sub_recv();
    wait_sub_rel(b_srel + 1);
    repeat (3) begin @(posedge clk_int); #1; end
    check("rsts_resume_q_drained", 256'(sub_q.size()), 256'(0));
    check("final_pub_q_drained", 256'(pub_q.size()), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
